ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
PS/2 device-to-host receiver sitting directly upstream of the scan-code shift register. Synchronises and glitch-filters the raw ps2_clk/ps2_data pins and deserialises 11-bit frames (start, 8 data bits LSB-first, odd parity, stop). For each valid frame it presents the byte on data and fires a one-cycle shren strobe. Malformed or stalled frames are dropped and flagged.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pin synchronisers (minimum 2).
FILTER_LEN, 4, consecutive clk cycles the synchronised ps2_clk must hold a new level before the filtered clock changes.
TIMEOUT_CYCLES, 5000, clk cycles without a filtered falling edge, mid-frame, before the frame is abandoned (100 us at 50 MHz).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-low reset.
en  in  1  receive enable; low holds FSM in IDLE and suppresses all outputs.
ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
ps2_data  in  1  raw PS/2 data pin, asynchronous.
data  out  8  last accepted byte; holds until the next accepted frame.
shren  out  1  one-cycle strobe, high in the cycle data updates.
busy  out  1  high whenever FSM is not IDLE.
parity_err  out  1  one-cycle pulse: frame had bad parity.
frame_err  out  1  one-cycle pulse: stop bit 0, or timeout.

Behaviour:
- Reset (rst low, async): FSM to IDLE; data=8'h00; shren, busy, parity_err, frame_err = 0; bit counter, timeout counter and shift register cleared; synchronisers and filter preset to 1 (bus idle).
- Sync: both pins pass through SYNC_STAGES flops. Filter: ps2_clk_f takes the new synchronised level only after FILTER_LEN consecutive equal samples; shorter pulses are ignored. fall = registered one-cycle pulse on ps2_clk_f 1->0. Bits are sampled from synchronised ps2_data in the fall cycle.
- FSM, advancing only on fall:
  IDLE: bit=0 -> DATA, cnt=0; bit=1 -> stay (no error).
  DATA: shift the bit in at MSB and shift right (LSB-first); after the 8th bit -> PARITY.
  PARITY: latch ok = XOR(byte, bit) == 1 -> STOP.
  STOP: bit=1 and ok -> data<=byte, shren=1; bit=1 and !ok -> parity_err=1; bit=0 -> frame_err=1 (takes precedence over parity). Always -> IDLE.
- Latency: shren asserts exactly SYNC_STAGES+FILTER_LEN+1 clk cycles after the stop-bit falling edge at the pin. The latency is constant.
- Timeout: counter clears on every fall and whenever the FSM is IDLE. At TIMEOUT_CYCLES-1 in a non-IDLE state -> IDLE, frame_err=1, counter cleared, byte discarded. If fall and timeout occur in the same cycle, fall wins.
- en low: FSM forced to IDLE the next cycle; any partial frame is discarded silently (no error pulse). Synchronisers keep running.
- Error and strobe outputs are mutually exclusive and never exceed one cycle. Back-to-back frames need no idle gap beyond the PS/2 stop bit.
- Reset mid-frame: immediate return to reset values; the next frame starts clean.

Decomposition:
- ps2_pkg: enum rx_state_t {IDLE, DATA, PARITY, STOP}; localparams FRAME_DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module ps2_sync_filter (parameters SYNC_STAGES, FILTER_LEN): outputs ps2_clk_f, fall, data_s. Same clk/rst.
- Timeout counter width = $clog2(TIMEOUT_CYCLES).

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> data=8'h1C, shren high exactly 1 cycle at SYNC_STAGES+FILTER_LEN+1 after the stop edge, no errors.
- Back-to-back 0xE0 (parity 0) then 0x75 (parity 0) -> two shren pulses; data=8'hE0 then 8'h75; busy drops only between frames.
- 0x1C sent with parity 1 -> parity_err one cycle, no shren, data unchanged; 0xF0 with parity 1 and stop 0 -> frame_err only.
- Start bit plus 5 data bits, then ps2_clk held high -> frame_err at TIMEOUT_CYCLES after the last edge, busy=0; a following 0xF0 (parity 1) frame is accepted.
- 2-cycle low glitch on ps2_clk in IDLE and mid-DATA (FILTER_LEN=4) -> ignored; a subsequent 0x1C frame is received correctly.
- rst low for 1 cycle after 4 data bits -> all outputs 0, FSM IDLE; next 0x75 frame accepted. en low mid-frame -> silent abort, no error pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

  // PS/2 uses odd parity: data bits plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] b, input logic p);
    return (^b) ^ p;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin synchronisers for ps2_clk/ps2_data plus a level filter on the clock that
// produces a registered one-cycle pulse on each filtered falling edge.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic ps2_clk_f,
  output logic fall,
  output logic data_s
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_s;
  logic                   clk_f_r;
  logic                   fall_r;
  logic [FW-1:0]          flt_cnt_r;

  assign clk_s     = clk_sync_r[SYNC_STAGES-1];
  assign data_s    = data_sync_r[SYNC_STAGES-1];
  assign ps2_clk_f = clk_f_r;
  assign fall      = fall_r;

  // Synchroniser chains, preset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_f_r   <= 1'b1;
      flt_cnt_r <= '0;
      fall_r    <= 1'b0;
    end else if (clk_s != clk_f_r) begin
      if (flt_cnt_r == FW'(FILTER_LEN - 1)) begin
        clk_f_r   <= clk_s;
        flt_cnt_r <= '0;
        fall_r    <= ~clk_s;
      end else begin
        flt_cnt_r <= flt_cnt_r + FW'(1);
        fall_r    <= 1'b0;
      end
    end else begin
      flt_cnt_r <= '0;
      fall_r    <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deserialises start/8 data/odd parity/stop
// frames on filtered clock falls, strobing shren for each good byte.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       shren,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W = $clog2(FRAME_DATA_BITS);

  logic                       clk_f_unused_s;
  logic                       fall_s;
  logic                       data_s;

  rx_state_t                  state_r, state_n;
  logic [CNT_W-1:0]           cnt_r, cnt_n;
  logic [TO_W-1:0]            to_r, to_n;
  logic [FRAME_DATA_BITS-1:0] shift_r, shift_n;
  logic                       ok_r, ok_n;
  logic [7:0]                 data_r, data_n;
  logic                       shren_r, shren_n;
  logic                       perr_r, perr_n;
  logic                       ferr_r, ferr_n;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_clk_f (clk_f_unused_s),
    .fall      (fall_s),
    .data_s    (data_s)
  );

  assign data       = data_r;
  assign shren      = shren_r;
  assign busy       = (state_r != IDLE);
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;

  // Next-state logic: en gates everything, then a fall advances the frame,
  // otherwise a stalled non-idle frame times out.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    to_n    = to_r;
    shift_n = shift_r;
    ok_n    = ok_r;
    data_n  = data_r;
    shren_n = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      to_n    = '0;
      shift_n = '0;
    end else if (fall_s) begin
      to_n = '0;
      case (state_r)
        IDLE: begin
          if (data_s == START_BIT) begin
            state_n = DATA;
            cnt_n   = '0;
            shift_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          shift_n = {data_s, shift_r[FRAME_DATA_BITS-1:1]};
          cnt_n   = cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(FRAME_DATA_BITS - 1)) begin
            state_n = PARITY;
          end else begin
            state_n = DATA;
          end
        end
        PARITY: begin
          ok_n    = odd_parity_ok(shift_r, data_s);
          state_n = STOP;
        end
        STOP: begin
          // A bad stop bit outranks a parity failure.
          if (data_s != STOP_BIT) begin
            ferr_n = 1'b1;
          end else if (ok_r) begin
            data_n  = shift_r;
            shren_n = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else if (state_r != IDLE) begin
      if (to_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_n = IDLE;
        ferr_n  = 1'b1;
        to_n    = '0;
        cnt_n   = '0;
        shift_n = '0;
      end else begin
        to_n = to_r + TO_W'(1);
      end
    end else begin
      to_n = '0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      to_r    <= '0;
      shift_r <= '0;
      ok_r    <= 1'b0;
      data_r  <= 8'h00;
      shren_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      to_r    <= to_n;
      shift_r <= shift_n;
      ok_r    <= ok_n;
      data_r  <= data_n;
      shren_r <= shren_n;
      perr_r  <= perr_n;
      ferr_r  <= ferr_n;
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: directed PS/2 frames push expected pulses,
// a monitor pops and checks kind, byte and arrival cycle.
module tb_ps2_rx_frame;

  localparam int S = 2;
  localparam int F = 4;
  localparam int T = 5000;
  localparam int LAT = S + F + 1;
  localparam int HALF = 10;
  localparam int K_SHREN = 0;
  localparam int K_PERR  = 1;
  localparam int K_FERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       shren, busy, parity_err, frame_err;

  int         total = 0;
  int         bad = 0;
  longint     cyc = 0;
  longint     last_fall = 0;
  logic [7:0] exp_data = 8'h00;

  typedef struct {
    int         kind;
    logic [7:0] d;
    longint     stamp;
  } exp_t;
  exp_t q[$];

  ps2_rx_frame #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .shren      (shren),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] d, input longint stamp);
    if (kind == K_SHREN) exp_data = d;
    q.push_back('{kind, exp_data, stamp});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit last, input int kind,
                          input logic [7:0] d, input bit glitch);
    ps2_data = b;
    wait_cyc(HALF);
    last_fall = cyc;
    if (last) push(kind, d, cyc + LAT);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(4);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input int kind, input int glitch_at);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == 10, kind, d, i == glitch_at);
    ps2_data = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(posedge clk) begin : monitor
    int   k;
    int   n;
    exp_t e;
    #1;
    if (shren || parity_err || frame_err) begin
      n = int'(shren) + int'(parity_err) + int'(frame_err);
      k = shren ? K_SHREN : (parity_err ? K_PERR : K_FERR);
      chk("exclusive_pulse", n, 1);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: kind %0d data 0x%0h at cycle %0d, none expected", k, data, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_data", data, e.d);
        chk("pulse_cycle", cyc, e.stamp);
      end
    end
  end

  initial begin
    wait_cyc(3);
    chk("reset_data", data, 8'h00);
    chk("reset_shren", shren, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_perr", parity_err, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    rst = 1'b1;
    wait_cyc(5);

    send_frame(8'h1C, 1'b0, 1'b1, 11, K_SHREN, -1);
    wait_cyc(20);
    chk("data_hold_1c", data, 8'h1C);

    send_frame(8'hE0, 1'b0, 1'b1, 11, K_SHREN, -1);
    send_frame(8'h75, 1'b0, 1'b1, 11, K_SHREN, -1);
    wait_cyc(20);
    chk("busy_after_b2b", busy, 1'b0);

    send_frame(8'h1C, 1'b1, 1'b1, 11, K_PERR, -1);
    send_frame(8'hF0, 1'b1, 1'b0, 11, K_FERR, -1);
    wait_cyc(20);
    chk("data_after_errs", data, 8'h75);

    // Stall after start plus five data bits.
    send_frame(8'h00, 1'b0, 1'b1, 6, K_SHREN, -1);
    push(K_FERR, 8'h00, last_fall + LAT + T);
    chk("busy_mid_frame", busy, 1'b1);
    wait_cyc(T + 20);
    chk("busy_after_timeout", busy, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 11, K_SHREN, -1);
    wait_cyc(20);

    // Short glitches in idle and mid-data.
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(20);
    chk("busy_after_idle_glitch", busy, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, K_SHREN, 3);
    wait_cyc(20);

    // Reset pulse after four data bits.
    send_frame(8'h75, 1'b0, 1'b1, 5, K_SHREN, -1);
    rst = 1'b0;
    #1;
    chk("midrst_data", data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_shren", shren, 1'b0);
    exp_data = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(20);
    send_frame(8'h75, 1'b0, 1'b1, 11, K_SHREN, -1);
    wait_cyc(20);

    // Enable dropped mid-frame: silent abort.
    send_frame(8'hAA, 1'b1, 1'b1, 4, K_SHREN, -1);
    en = 1'b0;
    wait_cyc(3);
    chk("en_low_busy", busy, 1'b0);
    wait_cyc(20);
    en = 1'b1;
    wait_cyc(10);
    send_frame(8'h1C, 1'b0, 1'b1, 11, K_SHREN, -1);
    wait_cyc(30);

    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
